// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus responder.
package m68k_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ACK,
        IACK,
        BERR
    } state_t;

    localparam logic [2:0] FC_IACK = 3'b111;
    localparam logic [1:0] DS_NONE = 2'b11;

    typedef struct packed {
        logic        we;
        logic [1:0]  be;
        logic [22:0] addr;
        logic [15:0] wdata;
    } bus_req_t;

    // A cycle only counts once a data strobe is present, so writes wait for DS.
    function automatic logic cycle_start(input logic as_n, input logic [1:0] ds_n);
        return !as_n && (ds_n != DS_NONE);
    endfunction

endpackage

// File: rtl/m68k_wait_counter.sv
// Saturating up-counter with synchronous clear; shared by the DTACK wait
// count and the device timeout count.
module m68k_wait_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/m68k_bus_responder.sv
// Target-side responder for the fx68k bus: one dev_req per CPU cycle, DTACKn
// after a minimum wait, VPAn for IACK. Define M68K_RESP_TIMEOUT_EN for BERRn on timeout.
//
// state | meaning
// IDLE  | waiting for AS plus a data strobe
// REQ   | device request outstanding or minimum wait not yet met
// ACK   | DTACKn asserted until the CPU releases AS/DS
// IACK  | autovector: VPAn asserted until AS rises
// BERR  | device timeout: BERRn asserted until AS rises
module m68k_bus_responder
    import m68k_bus_pkg::*;
#(
    parameter int WAIT_CYCLES    = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_as_n,
    input  logic [1:0]  cpu_ds_n,
    input  logic        cpu_rw,
    input  logic [2:0]  cpu_fc,
    input  logic [22:0] cpu_addr,
    input  logic [15:0] cpu_dout,
    output logic [15:0] cpu_din,
    output logic        cpu_dtack_n,
    output logic        cpu_vpa_n,
    output logic        cpu_berr_n,
    output logic        dev_req,
    output logic        dev_we,
    output logic [1:0]  dev_be,
    output logic [22:0] dev_addr,
    output logic [15:0] dev_wdata,
    input  logic        dev_ack,
    input  logic [15:0] dev_rdata
);

    localparam logic [3:0] WAIT_CMP = 4'(WAIT_CYCLES);

    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
        $error("m68k_bus_responder: WAIT_CYCLES must be 1..15");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("m68k_bus_responder: TIMEOUT_CYCLES must be 1..255");
    end

    state_t      state_q, state_d;
    bus_req_t    req_q, req_d;
    logic        dev_req_q, dev_req_d;
    logic        done_q, done_d;
    logic [15:0] din_q, din_d;
    logic        dtack_n_q, vpa_n_q;
    logic [3:0]  wait_cnt;
    logic        start, ack_take, timeout;

    assign start    = cycle_start(cpu_as_n, cpu_ds_n);
    assign ack_take = (state_q == REQ) && dev_req_q && dev_ack;

    m68k_wait_counter #(.WIDTH(4)) u_wait_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (state_q == IDLE),
        .en_i    (state_q == REQ),
        .count_o (wait_cnt)
    );

`ifdef M68K_RESP_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] to_cnt;
    logic       berr_n_q;

    m68k_wait_counter #(.WIDTH(8)) u_timeout_cnt (
        .clk     (clk),
        .reset   (reset),
        .clr_i   (state_q == IDLE),
        .en_i    ((state_q == REQ) && !done_q),
        .count_o (to_cnt)
    );

    // An ack in the expiry cycle wins: ack_take is checked first in REQ.
    assign timeout = (state_q == REQ) && !done_q && (to_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            berr_n_q <= 1'b1;
        end else begin
            berr_n_q <= (state_d != BERR);
        end
    end

    assign cpu_berr_n = berr_n_q;
`else
    assign timeout    = 1'b0;
    assign cpu_berr_n = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        dev_req_d = dev_req_q;
        done_d    = done_q;
        din_d     = din_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cpu_fc == FC_IACK) begin
                        state_d = IACK;
                    end else begin
                        state_d   = REQ;
                        req_d     = '{we: ~cpu_rw, be: ~cpu_ds_n, addr: cpu_addr, wdata: cpu_dout};
                        dev_req_d = 1'b1;
                        done_d    = 1'b0;
                    end
                end
            end
            REQ: begin
                if (cpu_as_n) begin
                    state_d   = IDLE;
                    dev_req_d = 1'b0;
                end else if (ack_take) begin
                    dev_req_d = 1'b0;
                    done_d    = 1'b1;
                    if (!req_q.we) begin
                        din_d = dev_rdata;
                    end
                end else if (done_q && (wait_cnt >= WAIT_CMP)) begin
                    state_d = ACK;
                end else if (timeout) begin
                    state_d   = BERR;
                    dev_req_d = 1'b0;
                end
            end
            ACK: begin
                if (cpu_as_n || (cpu_ds_n == DS_NONE)) begin
                    state_d = IDLE;
                end
            end
            IACK, BERR: begin
                if (cpu_as_n) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            req_q     <= '0;
            dev_req_q <= 1'b0;
            done_q    <= 1'b0;
            din_q     <= '0;
            dtack_n_q <= 1'b1;
            vpa_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            dev_req_q <= dev_req_d;
            done_q    <= done_d;
            din_q     <= din_d;
            dtack_n_q <= (state_d != ACK);
            vpa_n_q   <= (state_d != IACK);
        end
    end

    assign cpu_din     = din_q;
    assign cpu_dtack_n = dtack_n_q;
    assign cpu_vpa_n   = vpa_n_q;
    assign dev_req     = dev_req_q;
    assign dev_we      = req_q.we;
    assign dev_be      = req_q.be;
    assign dev_addr    = req_q.addr;
    assign dev_wdata   = req_q.wdata;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Directed bench for m68k_bus_responder: a cycle table on a WAIT_CYCLES=1
// instance plus hand sequences for the wait, timeout and reset corners.
module tb_m68k_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        as_n;
    logic [1:0]  ds_n;
    logic        rw;
    logic [2:0]  fc;
    logic [22:0] addr;
    logic [15:0] dout;
    logic [15:0] rdata;
    logic        ack1, ack4;

    logic [15:0] din1, din4;
    logic        dtack1, dtack4, vpa1, vpa4, berr1, berr4;
    logic        req1, req4, we1, we4;
    logic [1:0]  be1, be4;
    logic [22:0] daddr1, daddr4;
    logic [15:0] wdata1, wdata4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    m68k_bus_responder #(.WAIT_CYCLES(1), .TIMEOUT_CYCLES(8)) u_w1 (
        .clk(clk), .reset(reset), .cpu_as_n(as_n), .cpu_ds_n(ds_n), .cpu_rw(rw),
        .cpu_fc(fc), .cpu_addr(addr), .cpu_dout(dout), .cpu_din(din1),
        .cpu_dtack_n(dtack1), .cpu_vpa_n(vpa1), .cpu_berr_n(berr1),
        .dev_req(req1), .dev_we(we1), .dev_be(be1), .dev_addr(daddr1),
        .dev_wdata(wdata1), .dev_ack(ack1), .dev_rdata(rdata)
    );

    m68k_bus_responder #(.WAIT_CYCLES(4), .TIMEOUT_CYCLES(8)) u_w4 (
        .clk(clk), .reset(reset), .cpu_as_n(as_n), .cpu_ds_n(ds_n), .cpu_rw(rw),
        .cpu_fc(fc), .cpu_addr(addr), .cpu_dout(dout), .cpu_din(din4),
        .cpu_dtack_n(dtack4), .cpu_vpa_n(vpa4), .cpu_berr_n(berr4),
        .dev_req(req4), .dev_we(we4), .dev_be(be4), .dev_addr(daddr4),
        .dev_wdata(wdata4), .dev_ack(ack4), .dev_rdata(rdata)
    );

    typedef struct {
        logic        rst;
        logic        as_n;
        logic [1:0]  ds_n;
        logic        rw;
        logic [2:0]  fc;
        logic [22:0] addr;
        logic        ack;
        logic [15:0] rdata;
        logic        dtack_n;
        logic        vpa_n;
        logic        req;
        logic        chk;
        logic        we;
        logic [1:0]  be;
        logic [22:0] daddr;
        logic [15:0] din;
    } vec_t;

    localparam int NVEC = 19;
    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen_dtack;
        bit  seen_berr;

        // rst as ds rw fc addr ack rdata | dtack vpa req chk we be daddr din
        vecs[0]  = '{1'b1, 1'b1, 2'b11, 1'b1, 3'b000, 23'h000000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 23'h000000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h080000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 23'h080000, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h080000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h080000, 1'b1, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h080000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h080000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 1'b1, 3'b101, 23'h080000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[7]  = '{1'b0, 1'b1, 2'b11, 1'b1, 3'b000, 23'h000000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[8]  = '{1'b0, 1'b0, 2'b10, 1'b1, 3'b111, 23'h7FFFF8, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 1'b1, 3'b111, 23'h7FFFF8, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 1'b1, 3'b000, 23'h000000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'hBEEF};
        vecs[11] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h000010, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 23'h000010, 16'hBEEF};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h000010, 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h1111};
        vecs[13] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h000010, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h1111};
        vecs[14] = '{1'b0, 1'b1, 2'b11, 1'b1, 3'b101, 23'h000010, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h1111};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h000011, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11, 23'h000011, 16'h1111};
        vecs[16] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h000011, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h2222};
        vecs[17] = '{1'b0, 1'b0, 2'b00, 1'b1, 3'b101, 23'h000011, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h2222};
        vecs[18] = '{1'b0, 1'b1, 2'b11, 1'b1, 3'b101, 23'h000011, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h2222};

        reset = 1'b1; as_n = 1'b1; ds_n = 2'b11; rw = 1'b1; fc = 3'b000;
        addr = '0; dout = '0; rdata = '0; ack1 = 1'b0; ack4 = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            reset = vecs[i].rst;
            as_n  = vecs[i].as_n;
            ds_n  = vecs[i].ds_n;
            rw    = vecs[i].rw;
            fc    = vecs[i].fc;
            addr  = vecs[i].addr;
            ack1  = vecs[i].ack;
            rdata = vecs[i].rdata;
            tick();
            check($sformatf("v%0d dtack_n", i), 32'(dtack1), 32'(vecs[i].dtack_n));
            check($sformatf("v%0d vpa_n", i), 32'(vpa1), 32'(vecs[i].vpa_n));
            check($sformatf("v%0d dev_req", i), 32'(req1), 32'(vecs[i].req));
            check($sformatf("v%0d cpu_din", i), 32'(din1), 32'(vecs[i].din));
            check($sformatf("v%0d berr_n", i), 32'(berr1), 32'(1'b1));
            if (vecs[i].chk) begin
                check($sformatf("v%0d dev_we", i), 32'(we1), 32'(vecs[i].we));
                check($sformatf("v%0d dev_be", i), 32'(be1), 32'(vecs[i].be));
                check($sformatf("v%0d dev_addr", i), 32'(daddr1), 32'(vecs[i].daddr));
            end
        end
        ack1 = 1'b0;

        // Byte write, LDS only, WAIT_CYCLES=4 with immediate ack
        as_n = 1'b0; ds_n = 2'b10; rw = 1'b0; fc = 3'b101; addr = 23'h000100; dout = 16'h1234;
        tick();
        check("wr dev_req", 32'(req4), 32'(1'b1));
        check("wr dev_be", 32'(be4), 32'(2'b01));
        check("wr dev_we", 32'(we4), 32'(1'b1));
        check("wr dev_wdata", 32'(wdata4), 32'(16'h1234));
        check("wr dev_addr", 32'(daddr4), 32'(23'h000100));
        ack4 = 1'b1; rdata = 16'hDEAD;
        n = 0;
        seen_dtack = 1'b0;
        while (n < 20 && !seen_dtack) begin
            tick();
            ack4 = 1'b0;
            n++;
            if (n == 1) check("wr dev_req drop", 32'(req4), 32'(1'b0));
            if (dtack4 == 1'b0) seen_dtack = 1'b1;
        end
        check("wr dtack seen", 32'(seen_dtack), 32'(1'b1));
        check("wr dtack latency", 32'(n), 32'(5));
        check("wr cpu_din untouched", 32'(din4), 32'(16'h0000));
        as_n = 1'b1; ds_n = 2'b11; rw = 1'b1;
        tick();
        check("wr dtack release", 32'(dtack4), 32'(1'b1));
        tick();

        // Read with no device ack: timeout build raises BERRn, default build waits
        as_n = 1'b0; ds_n = 2'b00; rw = 1'b1; fc = 3'b101; addr = 23'h000200;
        tick();
        check("to dev_req", 32'(req1), 32'(1'b1));
        n = 0;
        seen_dtack = 1'b0;
        seen_berr = 1'b0;
        while (n < 30 && !seen_berr) begin
            tick();
            n++;
            if (dtack1 == 1'b0) seen_dtack = 1'b1;
            if (berr1 == 1'b0) seen_berr = 1'b1;
        end
        check("to no dtack", 32'(seen_dtack), 32'(1'b0));
`ifdef M68K_RESP_TIMEOUT_EN
        check("to berr seen", 32'(seen_berr), 32'(1'b1));
        check("to berr latency ok", 32'(n >= 8 && n <= 9), 32'(1));
        check("to dev_req drop", 32'(req1), 32'(1'b0));
        tick();
        check("to berr held", 32'(berr1), 32'(1'b0));
        as_n = 1'b1; ds_n = 2'b11;
        tick();
        check("to berr release", 32'(berr1), 32'(1'b1));
        check("to dtack idle", 32'(dtack1), 32'(1'b1));
`else
        check("to berr never", 32'(seen_berr), 32'(1'b0));
        check("to dev_req held", 32'(req1), 32'(1'b1));
        as_n = 1'b1; ds_n = 2'b11;
        tick();
        check("abort dev_req drop", 32'(req1), 32'(1'b0));
        check("abort dtack", 32'(dtack1), 32'(1'b1));
        check("abort berr", 32'(berr1), 32'(1'b1));
`endif
        tick();

        // Reset during REQ, then a stray ack
        as_n = 1'b0; ds_n = 2'b00; rw = 1'b1; addr = 23'h000300;
        tick();
        check("rst dev_req before", 32'(req1), 32'(1'b1));
        reset = 1'b1; as_n = 1'b1; ds_n = 2'b11;
        tick();
        check("rst dev_req", 32'(req1), 32'(1'b0));
        check("rst dtack_n", 32'(dtack1), 32'(1'b1));
        check("rst vpa_n", 32'(vpa1), 32'(1'b1));
        check("rst berr_n", 32'(berr1), 32'(1'b1));
        check("rst dev_be", 32'(be1), 32'(2'b00));
        check("rst dev_we", 32'(we1), 32'(1'b0));
        check("rst dev_addr", 32'(daddr1), 32'(23'h000000));
        check("rst dev_wdata", 32'(wdata1), 32'(16'h0000));
        check("rst cpu_din", 32'(din1), 32'(16'h0000));
        reset = 1'b0; ack1 = 1'b1; rdata = 16'h5555;
        tick();
        ack1 = 1'b0;
        check("rst late ack din", 32'(din1), 32'(16'h0000));
        check("rst late ack req", 32'(req1), 32'(1'b0));
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("rst no dtack %0d", k), 32'(dtack1), 32'(1'b1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/m68k_bus_responder.md
Name: m68k_bus_responder

Overview:
- Target-side responder for the fx68k asynchronous 68000 bus.
- Detects CPU bus cycles from AS/UDS/LDS/RW/FC and converts each into a single valid/ack request on a synchronous device port.
- Generates DTACKn after a programmable minimum wait, VPAn for interrupt-acknowledge (autovector) cycles, and optionally BERRn on a device timeout.
- Replaces ad-hoc DTACK logic in system tops; sits between the CPU core and the peripheral address decode/mux.

Parameters:
- WAIT_CYCLES, 1, minimum clk cycles from request start to DTACKn assertion (1..15).
- TIMEOUT_CYCLES, 255, clk cycles in REQ without dev_ack before BERRn (1..255; used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cpu_as_n  in  1  address strobe
- cpu_ds_n  in  2  [1]=UDSn, [0]=LDSn
- cpu_rw  in  1  1=read, 0=write
- cpu_fc  in  3  function code
- cpu_addr  in  23  word address (A23..A1)
- cpu_dout  in  16  CPU write data
- cpu_din  out  16  read data to CPU, registered
- cpu_dtack_n  out  1  data transfer acknowledge
- cpu_vpa_n  out  1  valid peripheral address (autovector)
- cpu_berr_n  out  1  bus error
- dev_req  out  1  request valid, level, held until dev_ack
- dev_we  out  1  1=write
- dev_be  out  2  byte enables, [1]=upper
- dev_addr  out  23  latched word address
- dev_wdata  out  16  latched write data
- dev_ack  in  1  single-cycle completion; dev_rdata valid in the same cycle
- dev_rdata  in  16  read data

Behaviour:
- Reset: synchronous, active-high; clock clk. On reset, state=IDLE; cpu_dtack_n=1, cpu_vpa_n=1, cpu_berr_n=1, dev_req=0, dev_we=0, dev_be=0, dev_addr=0, dev_wdata=0, cpu_din=0. Reset mid-transaction drops dev_req the next cycle; a dev_ack arriving after reset is ignored.
- Cycle start condition: cpu_as_n=0 and cpu_ds_n!=2'b11. A write cycle does not start on AS alone; the block waits for DS.
- IDLE:
  - Start with cpu_fc=3'b111 -> IACK.
  - Other start -> REQ. On entry, latch dev_addr=cpu_addr, dev_we=~cpu_rw, dev_be=~cpu_ds_n, dev_wdata=cpu_dout; set dev_req=1; clear the wait counter.
- REQ:
  - Wait counter increments each cycle and saturates at 15.
  - dev_ack captures dev_rdata into cpu_din (reads only), drops dev_req the next cycle, and sets an internal done flag.
  - When done=1 and counter>=WAIT_CYCLES -> ACK, with cpu_dtack_n=0 in the following cycle. With immediate ack and WAIT_CYCLES=1, DTACKn falls 2 cycles after the start condition is sampled.
- ACK: hold cpu_dtack_n=0 and cpu_din stable until cpu_as_n=1 or cpu_ds_n=2'b11 is sampled; then cpu_dtack_n=1 next cycle -> IDLE.
- IACK: cpu_vpa_n=0 the next cycle; no dev_req is issued. Hold until cpu_as_n=1 -> cpu_vpa_n=1 -> IDLE.
- Abort: cpu_as_n=1 while in REQ -> dev_req=0 next cycle, no DTACKn, return to IDLE. A late dev_ack outside REQ is ignored.
- Back-to-back: a new cycle starts only from IDLE. At least one IDLE cycle separates consecutive transactions, which guarantees DTACKn is negated between cycles.
- dev_ack in the same cycle dev_req is first asserted is legal and is counted.

Optional Feature:
- Macro M68K_RESP_TIMEOUT_EN.
- Defined: a timeout counter runs in REQ. When it reaches TIMEOUT_CYCLES without dev_ack:
  - dev_req=0;
  - state BERR, with cpu_berr_n=0 held until cpu_as_n=1;
  - cpu_dtack_n stays 1 throughout.
  If dev_ack and the timeout occur in the same cycle, the ack wins.
- Undefined: no timeout counter, cpu_berr_n tied to 1, and REQ waits indefinitely.

Decomposition:
- Package m68k_bus_pkg:
  - state enum (IDLE, REQ, ACK, IACK, BERR);
  - FC_IACK=3'b111;
  - DS_NONE=2'b11;
  - bus_req_t struct (we, be, addr, wdata).
- One natural sub-module, m68k_wait_counter: saturating up-counter with clear, used for both the wait count and the timeout count.

Test Plan:
- Word read of 0x100000, WAIT_CYCLES=1, dev_ack one cycle after dev_req with dev_rdata=16'hBEEF -> dev_we=0, dev_be=2'b11, dev_addr=23'h080000; cpu_din=16'hBEEF; DTACKn low until AS rises, then high the next cycle.
- Byte write with LDS only, cpu_dout=16'h1234, WAIT_CYCLES=4, dev_ack immediate -> dev_be=2'b01, dev_wdata=16'h1234; DTACKn asserts no earlier than 5 cycles after the start condition.
- IACK with fc=3'b111 and LDS=0 -> cpu_vpa_n=0 next cycle, dev_req never asserted, DTACKn stays 1, VPAn releases one cycle after AS rises.
- With M68K_RESP_TIMEOUT_EN and TIMEOUT_CYCLES=8, no dev_ack -> dev_req drops and cpu_berr_n=0 after 8 REQ cycles, DTACKn never asserts; with the macro undefined, cpu_berr_n stays 1.
- Reset asserted during REQ, followed by a dev_ack -> all outputs at reset values; the ack is ignored and no DTACKn is issued.
- Two back-to-back reads with AS high for one cycle between them -> two dev_req pulses, DTACKn negated between cycles, and correct cpu_din for each.
